segment_capture: RTL and testbench
==================================

SEGMENT_CAPTURE -- requirements
Module: segment_capture

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter STABLE_CYCLES, default 4, SHALL set the consecutive identical samples needed to accept a digit (legal range 2..15).
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 seg_in  input  7  segment pattern {g,f,e,d,c,b,a}, active-low (0 = segment lit).
REQ-006 digit_sel  input  6  digit enable; bit n selects digit n (0 = rightmost); legal only when exactly one bit is set.
REQ-007 digit_0 .. digit_5  output  4 each  last complete decoded frame, one value per digit.
REQ-008 frame_valid  output  1  one-cycle pulse when digit_0..digit_5 update.
REQ-009 pattern_err  output  1  sticky flag: an accepted pattern was not a legal digit.
REQ-010 sel_err  output  1  sticky flag: digit_sel had two or more bits set.
REQ-011 err_count  output  8  saturating count of rejected events (see Configuration).

Function
REQ-012 Per cycle, the block SHALL compare {digit_sel, seg_in} with the previous cycle's sample; equal values increment the stability counter, and different values reset it to 0.
REQ-013 When digit_sel is one-hot and the counter reaches STABLE_CYCLES-1, the decoded value SHALL be written to shadow slot n and captured bit n SHALL be set.
- Only one write per dwell: the counter holds at STABLE_CYCLES-1 until the sample changes.
REQ-014 Decode SHALL use the active-low map 0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9.
REQ-015 Any other pattern SHALL store 4'hF in the slot, set pattern_err, and count one error.
REQ-016 If digit_sel is all-zero, the sample SHALL be ignored: counter reset, nothing stored, no error.
REQ-017 If digit_sel has two or more bits set, nothing SHALL be stored, sel_err SHALL be set, and one error SHALL be counted per dwell (on reaching STABLE_CYCLES-1).
REQ-018 On the cycle after all six captured bits are set:
- shadow slots copy atomically to digit_0..5;
- frame_valid pulses high for exactly one cycle;
- all captured bits clear.
REQ-019 Re-capturing a slot before the frame completes SHALL overwrite the shadow value (latest wins).
REQ-020 A capture on the same cycle as the frame copy SHALL land in the new frame (captured bit set after clear).
REQ-021 Latency SHALL be STABLE_CYCLES+1 clocks from the first stable sample of the sixth digit to frame_valid.

Reset
REQ-022 Reset SHALL be asynchronous, active-high, and apply immediately, including mid-dwell or mid-frame.
REQ-023 On reset SHALL clear to 0:
- digit_0..5, frame_valid, pattern_err, sel_err, err_count;
- shadow slots, captured bits, stability counter, previous-sample register.
REQ-024 The first sample after reset release SHALL start a new dwell; a partially collected frame SHALL be discarded.

Configuration
REQ-025 With macro SEGMENT_CAPTURE_ERR_CNT_EN defined, err_count SHALL increment on each event in REQ-015 and REQ-017 and saturate at 255.
REQ-026 Without it, err_count SHALL be constant 0 and no counter logic SHALL be built; the sticky flags are unaffected.

Structure
REQ-027 The shared display package SHALL hold:
- the ten segment-pattern constants, shared with the display encoder;
- the illegal-digit code 4'hF;
- the digit-count constant 6.
REQ-028 The pattern-to-digit decode SHALL be a combinational sub-module, seg_pattern_decode (7-bit in; 4-bit digit and legal flag out).

Verification (STABLE_CYCLES=4)
REQ-029 Reset release:
- stimulus: drive digits 5..0 = 1,2,3,4,5,6, each held 6 cycles in order 0..5;
- response: one frame_valid pulse; digit_5..0 = 1,2,3,4,5,6; no error flags.
REQ-030 Glitch:
- stimulus: digit 2 pattern 0x24 held 3 cycles, then 0x30 held 4 cycles;
- response: slot 2 = 3; nothing stored from the 3-cycle dwell.
REQ-031 Illegal pattern:
- stimulus: 0x7F on digit 4 for 4 cycles, then complete the frame;
- response: digit_4 = 4'hF; pattern_err = 1; err_count = 1 (macro defined) or 0 (undefined).
REQ-032 Illegal select:
- stimulus: digit_sel = 6'b000011 for 10 cycles;
- response: sel_err = 1; err_count +1; no slot written; no frame_valid.
REQ-033 Reset mid-operation:
- stimulus: assert reset after 5 slots are captured;
- response: all outputs 0 asynchronously; after release, frame_valid only once all 6 digits are recaptured.
REQ-034 Saturation:
- stimulus: 300 illegal-pattern dwells with the macro defined;
- response: err_count holds at 255.

Source files
------------

// File: rtl/segment_capture_pkg.sv
// Shared display constants: segment patterns, illegal-digit code, digit count.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package segment_capture_pkg;

   // Number of digit positions on the multiplexed display.
   localparam int NUM_DIGITS = 6;

   // Code stored for a pattern that is not one of the ten legal digits.
   localparam logic [3:0] DIGIT_ILLEGAL = 4'hF;

   // Active-low segment patterns {g,f,e,d,c,b,a}, shared with the display encoder.
   localparam logic [6:0] SEG_PAT_0 = 7'h40;
   localparam logic [6:0] SEG_PAT_1 = 7'h79;
   localparam logic [6:0] SEG_PAT_2 = 7'h24;
   localparam logic [6:0] SEG_PAT_3 = 7'h30;
   localparam logic [6:0] SEG_PAT_4 = 7'h19;
   localparam logic [6:0] SEG_PAT_5 = 7'h12;
   localparam logic [6:0] SEG_PAT_6 = 7'h02;
   localparam logic [6:0] SEG_PAT_7 = 7'h78;
   localparam logic [6:0] SEG_PAT_8 = 7'h00;
   localparam logic [6:0] SEG_PAT_9 = 7'h10;

   // How many digit enables are active in one sample.
   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_ONE   = 2'd1,
      SEL_MULTI = 2'd2
   } sel_class_t;

   // One observed bus sample; the stability counter compares whole samples.
   typedef struct packed {
      logic [NUM_DIGITS-1:0] sel;
      logic [6:0]            seg;
   } sample_t;

   // Classify a digit-enable vector as idle, one-hot or conflicting.
   function automatic sel_class_t classify_sel(input logic [NUM_DIGITS-1:0] sel);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         ones = ones + {31'd0, sel[i]};
      end
      if (ones == 0) begin
         return SEL_NONE;
      end else if (ones == 1) begin
         return SEL_ONE;
      end
      return SEL_MULTI;
   endfunction

endpackage

// File: rtl/segment_capture_decode.sv
// Combinational seven-segment pattern to BCD digit decoder with legality flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input continuously.
import segment_capture_pkg::*;

module seg_pattern_decode (
   input  logic [6:0] i_pattern,
   output logic [3:0] o_digit,
   output logic       o_legal
);

   // Map each legal active-low pattern to its digit; anything else is illegal.
   always_comb begin
      o_digit = DIGIT_ILLEGAL;
      o_legal = 1'b0;
      case (i_pattern)
         SEG_PAT_0: begin o_digit = 4'd0; o_legal = 1'b1; end
         SEG_PAT_1: begin o_digit = 4'd1; o_legal = 1'b1; end
         SEG_PAT_2: begin o_digit = 4'd2; o_legal = 1'b1; end
         SEG_PAT_3: begin o_digit = 4'd3; o_legal = 1'b1; end
         SEG_PAT_4: begin o_digit = 4'd4; o_legal = 1'b1; end
         SEG_PAT_5: begin o_digit = 4'd5; o_legal = 1'b1; end
         SEG_PAT_6: begin o_digit = 4'd6; o_legal = 1'b1; end
         SEG_PAT_7: begin o_digit = 4'd7; o_legal = 1'b1; end
         SEG_PAT_8: begin o_digit = 4'd8; o_legal = 1'b1; end
         SEG_PAT_9: begin o_digit = 4'd9; o_legal = 1'b1; end
         default:   begin o_digit = DIGIT_ILLEGAL; o_legal = 1'b0; end
      endcase
   end

endmodule

// File: rtl/segment_capture.sv
// Samples a multiplexed 7-seg bus, debounces each digit, and publishes whole frames.
// Latency: STABLE_CYCLES+1 clocks from first stable sample of the last digit to o_frame_valid.
// Backpressure: none; the bus is sampled every cycle. Optional err_count: SEGMENT_CAPTURE_ERR_CNT_EN.
import segment_capture_pkg::*;

module segment_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic [6:0] i_seg_in,
   input  logic [5:0] i_digit_sel,
   output logic [3:0] o_digit_0,
   output logic [3:0] o_digit_1,
   output logic [3:0] o_digit_2,
   output logic [3:0] o_digit_3,
   output logic [3:0] o_digit_4,
   output logic [3:0] o_digit_5,
   output logic       o_frame_valid,
   output logic       o_pattern_err,
   output logic       o_sel_err,
   output logic [7:0] o_err_count
);

   // Counter saturates at CNT_HOLD; a dwell is accepted on the step from CNT_PRE.
   localparam logic [3:0] CNT_HOLD = 4'(STABLE_CYCLES - 1);
   localparam logic [3:0] CNT_PRE  = 4'(STABLE_CYCLES - 2);

   sample_t                 w_sample;
   sample_t                 r_prev;
   logic [3:0]              r_cnt;
   sel_class_t              w_sel_class;
   logic                    w_same;
   logic                    w_accept;
   logic                    w_accept_one;
   logic                    w_accept_multi;
   logic [3:0]              w_dec_digit;
   logic                    w_dec_legal;
   logic                    w_pat_err_evt;
   logic                    w_frame_done;
   logic [NUM_DIGITS-1:0]   w_cap_set;
   logic [NUM_DIGITS-1:0]   r_captured;
   logic [3:0]              r_shadow [NUM_DIGITS];
   logic [3:0]              r_digit  [NUM_DIGITS];
   logic                    r_frame_valid;
   logic                    r_pattern_err;
   logic                    r_sel_err;

   assign w_sample    = {i_digit_sel, i_seg_in};
   assign w_sel_class = classify_sel(i_digit_sel);
   assign w_same      = (w_sample == r_prev);

   // A dwell is accepted exactly once: on the cycle the counter would reach CNT_HOLD.
   assign w_accept       = w_same && (r_cnt == CNT_PRE) && (w_sel_class != SEL_NONE);
   assign w_accept_one   = w_accept && (w_sel_class == SEL_ONE);
   assign w_accept_multi = w_accept && (w_sel_class == SEL_MULTI);
   assign w_pat_err_evt  = w_accept_one && !w_dec_legal;

   // All slots captured: next edge publishes the frame and starts a new one.
   assign w_frame_done = &r_captured;
   assign w_cap_set    = w_accept_one ? i_digit_sel : '0;

   seg_pattern_decode u_decode (
      .i_pattern (i_seg_in),
      .o_digit   (w_dec_digit),
      .o_legal   (w_dec_legal)
   );

   // Previous-sample register and stability counter; idle or changed samples restart the dwell.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_prev <= '0;
         r_cnt  <= '0;
      end else begin
         r_prev <= w_sample;
         if ((w_sel_class == SEL_NONE) || !w_same) begin
            r_cnt <= '0;
         end else if (r_cnt != CNT_HOLD) begin
            r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   // Shadow slots: latest accepted value per digit wins until the frame is published.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int n = 0; n < NUM_DIGITS; n++) begin
            r_shadow[n] <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_DIGITS; n++) begin
            if (w_accept_one && i_digit_sel[n]) begin
               r_shadow[n] <= w_dec_digit;
            end
         end
      end
   end

   // Captured bits: cleared on publish, but a same-cycle capture belongs to the new frame.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_captured <= '0;
      end else begin
         r_captured <= (w_frame_done ? '0 : r_captured) | w_cap_set;
      end
   end

   // Publish: copy all shadow slots at once and pulse frame_valid for one cycle.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_frame_valid <= 1'b0;
         for (int n = 0; n < NUM_DIGITS; n++) begin
            r_digit[n] <= '0;
         end
      end else begin
         r_frame_valid <= w_frame_done;
         if (w_frame_done) begin
            for (int n = 0; n < NUM_DIGITS; n++) begin
               r_digit[n] <= r_shadow[n];
            end
         end
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_pattern_err <= 1'b0;
         r_sel_err     <= 1'b0;
      end else begin
         if (w_pat_err_evt) begin
            r_pattern_err <= 1'b1;
         end
         if (w_accept_multi) begin
            r_sel_err <= 1'b1;
         end
      end
   end

`ifdef SEGMENT_CAPTURE_ERR_CNT_EN
   logic       w_err_evt;
   logic [7:0] r_err_count;

   assign w_err_evt = w_pat_err_evt || w_accept_multi;

   // Saturating count of rejected dwells (illegal pattern or conflicting select).
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_err_count <= '0;
      end else if (w_err_evt && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign o_err_count = r_err_count;
`else
   assign o_err_count = '0;
`endif

   assign o_digit_0     = r_digit[0];
   assign o_digit_1     = r_digit[1];
   assign o_digit_2     = r_digit[2];
   assign o_digit_3     = r_digit[3];
   assign o_digit_4     = r_digit[4];
   assign o_digit_5     = r_digit[5];
   assign o_frame_valid = r_frame_valid;
   assign o_pattern_err = r_pattern_err;
   assign o_sel_err     = r_sel_err;

endmodule

// File: tb/tb_segment_capture.sv
module tb_segment_capture;

   localparam int S = 4;
`ifdef SEGMENT_CAPTURE_ERR_CNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg;
   logic [5:0] sel;
   logic [3:0] d0, d1, d2, d3, d4, d5;
   logic       fv, perr, serr;
   logic [7:0] errc;
   wire [23:0] w_dig = {d5, d4, d3, d2, d1, d0};

   int n_tests = 0;
   int n_fail  = 0;
   int fv_pulses = 0;
   int fv_mism   = 0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // reference model state
   logic [12:0] m_last;
   int          m_run;
   logic [3:0]  m_shadow [6];
   logic [3:0]  m_digit  [6];
   logic [5:0]  m_cap;
   logic        m_fv, m_perr, m_serr;
   int          m_err;

   segment_capture #(.STABLE_CYCLES(S)) dut (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_seg_in      (seg),
      .i_digit_sel   (sel),
      .o_digit_0     (d0),
      .o_digit_1     (d1),
      .o_digit_2     (d2),
      .o_digit_3     (d3),
      .o_digit_4     (d4),
      .o_digit_5     (d5),
      .o_frame_valid (fv),
      .o_pattern_err (perr),
      .o_sel_err     (serr),
      .o_err_count   (errc)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
      $fatal(1);
   end

   function automatic logic [4:0] ref_decode(input logic [6:0] p);
      for (int i = 0; i < 10; i++) begin
         if (seg_tab[i] == p) return {1'b1, 4'(i)};
      end
      return {1'b0, 4'hF};
   endfunction

   function automatic logic [23:0] exp_dig();
      return {m_digit[5], m_digit[4], m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
   endfunction

   function automatic logic [7:0] exp_err();
      return ERR_EN ? 8'(m_err) : 8'd0;
   endfunction

   task automatic model_reset();
      m_last = '0; m_run = 0; m_cap = '0;
      m_fv = 0; m_perr = 0; m_serr = 0; m_err = 0;
      for (int k = 0; k < 6; k++) begin m_shadow[k] = '0; m_digit[k] = '0; end
   endtask

   // One clock edge of the behaviour: publish a full frame, then judge the run of identical samples.
   task automatic model_edge();
      logic       fire;
      logic [4:0] dec;
      int         ones;
      fire = 1'b0;
      if (m_cap == 6'h3F) begin
         for (int k = 0; k < 6; k++) m_digit[k] = m_shadow[k];
         m_cap = '0;
         m_fv  = 1'b1;
      end else begin
         m_fv = 1'b0;
      end
      ones = $countones(sel);
      if (ones == 0) begin
         m_run = 0;
      end else if ({sel, seg} == m_last) begin
         if (m_run < S) begin
            m_run = m_run + 1;
            fire  = (m_run == S);
         end
      end else begin
         m_run = 1;
      end
      if (fire && ones == 1) begin
         dec = ref_decode(seg);
         for (int k = 0; k < 6; k++) begin
            if (sel[k]) begin m_shadow[k] = dec[3:0]; m_cap[k] = 1'b1; end
         end
         if (!dec[4]) begin
            m_perr = 1'b1;
            if (m_err < 255) m_err = m_err + 1;
         end
      end else if (fire) begin
         m_serr = 1'b1;
         if (m_err < 255) m_err = m_err + 1;
      end
      m_last = {sel, seg};
   endtask

   task automatic step(input logic [5:0] s, input logic [6:0] p);
      sel = s; seg = p;
      @(posedge clk);
      model_edge();
      #1;
      if (fv === 1'b1) fv_pulses++;
      if (fv !== m_fv) fv_mism++;
   endtask

   task automatic hold(input logic [5:0] s, input logic [6:0] p, input int n);
      for (int i = 0; i < n; i++) step(s, p);
   endtask

   task automatic do_reset();
      rst = 1'b1; sel = '0; seg = '0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      fv_pulses = 0;
      fv_mism   = 0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++; if (w_dig !== 24'h0) begin n_fail++; $display("FAIL reset_digits: got %h want 000000", w_dig); end
      n_tests++; if (fv !== 1'b0) begin n_fail++; $display("FAIL reset_fv: got %b want 0", fv); end
      n_tests++; if (perr !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", perr); end
      n_tests++; if (serr !== 1'b0) begin n_fail++; $display("FAIL reset_serr: got %b want 0", serr); end
      n_tests++; if (errc !== 8'd0) begin n_fail++; $display("FAIL reset_errc: got %0d want 0", errc); end
   endtask

   task automatic test_frame();
      int fv_at;
      do_reset();
      fv_at = 0;
      for (int n = 0; n < 6; n++) begin
         for (int c = 0; c < 6; c++) begin
            step(6'(1 << n), seg_tab[6 - n]);
            if (n == 5 && fv_at == 0 && fv === 1'b1) fv_at = c + 1;
         end
      end
      hold(6'd0, 7'h7F, 3);
      n_tests++; if (fv_pulses != 1) begin n_fail++; $display("FAIL frame_pulses: got %0d want 1", fv_pulses); end
      n_tests++; if (w_dig !== 24'h123456) begin n_fail++; $display("FAIL frame_digits: got %h want 123456", w_dig); end
      n_tests++; if (fv_at != S + 1) begin n_fail++; $display("FAIL frame_latency: got %0d want %0d", fv_at, S + 1); end
      n_tests++; if ({perr, serr, errc} !== 10'd0) begin n_fail++; $display("FAIL frame_errflags: got %b%b/%0d want 00/0", perr, serr, errc); end
      n_tests++; if (fv_mism != 0) begin n_fail++; $display("FAIL frame_fv_timing: got %0d mismatching cycles want 0", fv_mism); end
   endtask

   task automatic test_glitch();
      fv_pulses = 0;
      for (int n = 0; n < 6; n++) begin
         if (n != 2) hold(6'(1 << n), seg_tab[7], 5);
      end
      hold(6'b000100, 7'h24, 3);
      step(6'b000100, 7'h30);
      n_tests++; if (fv_pulses != 0) begin n_fail++; $display("FAIL glitch_short_dwell: got %0d pulses want 0", fv_pulses); end
      hold(6'b000100, 7'h30, 3);
      hold(6'd0, 7'h00, 2);
      n_tests++; if (fv_pulses != 1) begin n_fail++; $display("FAIL glitch_pulses: got %0d want 1", fv_pulses); end
      n_tests++; if (w_dig !== 24'h777377) begin n_fail++; $display("FAIL glitch_digits: got %h want 777377", w_dig); end
      n_tests++; if (fv_mism != 0) begin n_fail++; $display("FAIL glitch_fv_timing: got %0d mismatching cycles want 0", fv_mism); end
   endtask

   task automatic test_illegal_pattern();
      do_reset();
      hold(6'b010000, 7'h7F, 4);
      for (int n = 0; n < 6; n++) begin
         if (n != 4) hold(6'(1 << n), seg_tab[0], 5);
      end
      hold(6'd0, 7'h00, 2);
      n_tests++; if (w_dig !== 24'h0F0000) begin n_fail++; $display("FAIL illpat_digits: got %h want 0f0000", w_dig); end
      n_tests++; if (perr !== 1'b1) begin n_fail++; $display("FAIL illpat_perr: got %b want 1", perr); end
      n_tests++; if (serr !== 1'b0) begin n_fail++; $display("FAIL illpat_serr: got %b want 0", serr); end
      n_tests++; if (errc !== (ERR_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL illpat_errc: got %0d want %0d", errc, ERR_EN ? 1 : 0); end
      n_tests++; if (fv_pulses != 1) begin n_fail++; $display("FAIL illpat_pulses: got %0d want 1", fv_pulses); end
   endtask

   task automatic test_illegal_select();
      do_reset();
      hold(6'b000011, 7'h40, 10);
      n_tests++; if (serr !== 1'b1) begin n_fail++; $display("FAIL illsel_serr: got %b want 1", serr); end
      n_tests++; if (perr !== 1'b0) begin n_fail++; $display("FAIL illsel_perr: got %b want 0", perr); end
      n_tests++; if (errc !== (ERR_EN ? 8'd1 : 8'd0)) begin n_fail++; $display("FAIL illsel_errc: got %0d want %0d", errc, ERR_EN ? 1 : 0); end
      for (int n = 2; n < 6; n++) hold(6'(1 << n), seg_tab[8], 5);
      hold(6'd0, 7'h00, 2);
      n_tests++; if (fv_pulses != 0) begin n_fail++; $display("FAIL illsel_no_slot: got %0d pulses want 0", fv_pulses); end
      for (int n = 0; n < 2; n++) hold(6'(1 << n), seg_tab[9], 5);
      hold(6'd0, 7'h00, 2);
      n_tests++; if (fv_pulses != 1) begin n_fail++; $display("FAIL illsel_pulses: got %0d want 1", fv_pulses); end
      n_tests++; if (w_dig !== 24'h888899) begin n_fail++; $display("FAIL illsel_digits: got %h want 888899", w_dig); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      hold(6'b100001, 7'h40, 4);
      hold(6'b000001, 7'h7F, 4);
      for (int n = 1; n < 6; n++) hold(6'(1 << n), seg_tab[n + 1], 5);
      hold(6'd0, 7'h00, 2);
      n_tests++; if (w_dig !== 24'h65432F) begin n_fail++; $display("FAIL rmid_first_frame: got %h want 65432f", w_dig); end
      for (int n = 0; n < 5; n++) hold(6'(1 << n), seg_tab[2], 5);
      rst = 1'b1;
      #1;
      n_tests++; if (w_dig !== 24'h0) begin n_fail++; $display("FAIL rmid_digits: got %h want 000000", w_dig); end
      n_tests++; if ({fv, perr, serr, errc} !== 11'd0) begin n_fail++; $display("FAIL rmid_flags: got fv%b p%b s%b e%0d want all 0", fv, perr, serr, errc); end
      do_reset();
      hold(6'b100000, seg_tab[3], 5);
      hold(6'd0, 7'h00, 2);
      n_tests++; if (fv_pulses != 0) begin n_fail++; $display("FAIL rmid_discard: got %0d pulses want 0", fv_pulses); end
      for (int n = 0; n < 5; n++) hold(6'(1 << n), seg_tab[4], 5);
      hold(6'd0, 7'h00, 2);
      n_tests++; if (fv_pulses != 1) begin n_fail++; $display("FAIL rmid_pulses: got %0d want 1", fv_pulses); end
      n_tests++; if (w_dig !== 24'h344444) begin n_fail++; $display("FAIL rmid_digits_after: got %h want 344444", w_dig); end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         hold(6'b000001, 7'h7F, 4);
         step(6'd0, 7'h00);
         if (i == 253) begin
            n_tests++; if (errc !== (ERR_EN ? 8'd254 : 8'd0)) begin n_fail++; $display("FAIL sat_254: got %0d want %0d", errc, ERR_EN ? 254 : 0); end
         end
         if (i == 254) begin
            n_tests++; if (errc !== (ERR_EN ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL sat_255: got %0d want %0d", errc, ERR_EN ? 255 : 0); end
         end
      end
      n_tests++; if (errc !== (ERR_EN ? 8'd255 : 8'd0)) begin n_fail++; $display("FAIL sat_hold: got %0d want %0d", errc, ERR_EN ? 255 : 0); end
      n_tests++; if (perr !== 1'b1) begin n_fail++; $display("FAIL sat_perr: got %b want 1", perr); end
   endtask

   task automatic test_random();
      logic [5:0] s;
      logic [6:0] p;
      int         len, cls, cycles;
      do_reset();
      cycles = 0;
      while (cycles < 2000) begin
         cls = $urandom_range(0, 9);
         if (cls == 0) begin
            s = '0;
         end else if (cls <= 2) begin
            s = 6'($urandom);
            while ($countones(s) < 2) s = 6'($urandom);
         end else begin
            s = 6'(1 << $urandom_range(0, 5));
         end
         p   = ($urandom_range(0, 9) < 8) ? seg_tab[$urandom_range(0, 9)] : 7'($urandom);
         len = $urandom_range(1, 7);
         for (int i = 0; i < len; i++) begin
            step(s, p);
            cycles++;
            n_tests++;
            if ({fv, perr, serr, errc, w_dig} !== {m_fv, m_perr, m_serr, exp_err(), exp_dig()}) begin
               n_fail++;
               $display("FAIL random_cycle%0d: got fv%b p%b s%b e%0d d%h want fv%b p%b s%b e%0d d%h",
                        cycles, fv, perr, serr, errc, w_dig, m_fv, m_perr, m_serr, exp_err(), exp_dig());
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; sel = '0; seg = '0;
      test_reset();
      test_frame();
      test_glitch();
      test_illegal_pattern();
      test_illegal_select();
      test_reset_mid();
      test_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
